// File: rtl/if_stage.sv
// Instruction fetch stage: issues memory reads while the fetch buffer has room and
// presents returned instructions, tagged with their fetch address, to decode in program order.
module if_stage #(
   parameter int unsigned AW    = 5,
   parameter int unsigned IW    = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] pc_in,
   output logic          pc_en,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic [IW-1:0] imem_rdata,
   input  logic          flush,
   output logic          id_valid,
   input  logic          id_ready,
   output logic [IW-1:0] id_instr,
   output logic [AW-1:0] id_pc
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned OW = CW + 1;

   logic [IW-1:0] instr_mem_q [DEPTH];
   logic [AW-1:0] pc_mem_q    [DEPTH];

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          inflight_q, inflight_d;
   logic [AW-1:0] inflight_pc_q, inflight_pc_d;

   logic          pop;
   logic          push;
   logic [OW-1:0] occupancy;

   // Occupancy counts the in-flight read as already holding a slot, so a
   // returning instruction always has somewhere to land.
   always_comb begin
      pop       = (count_q != '0) && id_ready;
      push      = inflight_q && !flush;
      occupancy = OW'(count_q) + OW'(inflight_q) - OW'(pop);
      imem_req  = !reset && !flush && (occupancy < OW'(DEPTH));
      pc_en     = imem_req;
      imem_addr = pc_in;
      id_valid  = (count_q != '0);
      id_instr  = instr_mem_q[rd_ptr_q];
      id_pc     = pc_mem_q[rd_ptr_q];
   end

   always_comb begin
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      inflight_d    = imem_req;
      inflight_pc_d = inflight_pc_q;
      if (imem_req) begin
         inflight_pc_d = pc_in;
      end
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   // Buffer storage carries no reset; validity is tracked solely by count_q.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem_q[wr_ptr_q] <= imem_rdata;
         pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: queue-based reference of the fetch pipeline
// driven through directed scenarios followed by randomized ready/flush/reset traffic.
module tb_if_stage;

   localparam int unsigned AW    = 5;
   localparam int unsigned IW    = 8;
   localparam int unsigned DEPTH = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] pc_in;
   logic          pc_en;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_rdata;
   logic          flush;
   logic          id_valid;
   logic          id_ready;
   logic [IW-1:0] id_instr;
   logic [AW-1:0] id_pc;

   if_stage #(.AW(AW), .IW(IW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .pc_in     (pc_in),
      .pc_en     (pc_en),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_rdata(imem_rdata),
      .flush     (flush),
      .id_valid  (id_valid),
      .id_ready  (id_ready),
      .id_instr  (id_instr),
      .id_pc     (id_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IW-1:0] instr;
      logic [AW-1:0] pc;
   } ent_t;

   ent_t          q[$];
   bit            m_infl;
   logic [AW-1:0] m_infl_pc;
   logic [AW-1:0] pc_model;
   logic [IW-1:0] mem [32];

   int vectors    = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check outputs mid-cycle, advance the model at the edge,
   // then answer the memory read and advance the PC stage model.
   task automatic tick();
      bit pop;
      bit exp_req;
      if (reset) begin
         q.delete();
         m_infl = 1'b0;
      end
      @(negedge clk);
      pop     = (q.size() != 0) && id_ready;
      exp_req = !reset && !flush && ((q.size() + int'(m_infl) - int'(pop)) < DEPTH);
      chk("id_valid", 32'(id_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         chk("id_instr", 32'(id_instr), 32'(q[0].instr));
         chk("id_pc", 32'(id_pc), 32'(q[0].pc));
      end
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      chk("pc_en", 32'(pc_en), 32'(exp_req));
      if (exp_req) chk("imem_addr", 32'(imem_addr), 32'(pc_model));
      @(posedge clk);
      if (reset || flush) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (m_infl) q.push_back('{instr: imem_rdata, pc: m_infl_pc});
      end
      m_infl = exp_req;
      if (exp_req) m_infl_pc = pc_model;
      #1;
      imem_rdata = exp_req ? mem[pc_model] : IW'($urandom);
      if (exp_req) pc_model = pc_model + AW'(1);
      pc_in = pc_model;
   endtask

   initial begin
      reset      = 1'b1;
      flush      = 1'b0;
      id_ready   = 1'b0;
      pc_model   = '0;
      pc_in      = '0;
      imem_rdata = '0;
      m_infl     = 1'b0;
      m_infl_pc  = '0;
      for (int i = 0; i < 32; i++) mem[i] = IW'(i + 8'h10);

      repeat (2) tick();
      reset = 1'b0;

      // streaming, then redirect to 20 with pc 5 in flight and pc 4 buffered
      id_ready = 1'b1;
      repeat (6) tick();
      flush = 1'b1; pc_model = AW'(20); pc_in = pc_model;
      tick();
      flush = 1'b0;
      repeat (6) tick();

      // address wrap 30,31,0,1
      flush = 1'b1; pc_model = AW'(30); pc_in = pc_model;
      tick();
      flush = 1'b0;
      repeat (8) tick();

      // backpressure from reset, then release
      reset = 1'b1; pc_model = '0; pc_in = '0; id_ready = 1'b0;
      tick();
      reset = 1'b0;
      repeat (6) tick();
      id_ready = 1'b1;
      repeat (5) tick();

      // held flush
      flush = 1'b1;
      repeat (3) tick();
      flush = 1'b0;
      repeat (3) tick();

      // reset mid-stream with entries buffered
      id_ready = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0; id_ready = 1'b1;
      repeat (5) tick();

      // randomized traffic with arbitrary memory contents
      for (int i = 0; i < 32; i++) mem[i] = IW'($urandom);
      repeat (400) begin
         id_ready = ($urandom_range(0, 3) != 0);
         flush    = ($urandom_range(0, 15) == 0);
         reset    = ($urandom_range(0, 63) == 0);
         if (flush) begin
            pc_model = AW'($urandom);
            pc_in    = pc_model;
         end
         tick();
      end
      reset = 1'b0; flush = 1'b0;
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
